// File: rtl/bird_launcher_pkg.sv
// Shared game definitions for the bird launcher: state encoding, fixed-point
// scale, output widths and the launch speed computation.
package bird_launcher_pkg;

    localparam int FIXED_POINT_MULTIPLIER = 64;
    localparam int SPEED_W                = 11;
    localparam int BIRD_W                 = 3;
    localparam int MAX_SPEED              = 1023;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHARGING,
        ST_ARMED,
        ST_IN_FLIGHT,
        ST_COOLDOWN,
        ST_EMPTY
    } launcher_state_t;

    // Wide arithmetic so large parameters clamp instead of wrapping.
    function automatic logic [SPEED_W-1:0] calc_speed(input int charge,
                                                      input int min_speed,
                                                      input int step);
        int raw;
        raw = min_speed + charge * step;
        if (raw > MAX_SPEED) raw = MAX_SPEED;
        if (raw < 0)         raw = 0;
        return raw[SPEED_W-1:0];
    endfunction

endpackage

// File: rtl/bird_launcher_key_sync_edge.sv
// Two-flop synchronizer for an asynchronous key, with one-clock rise/fall
// pulses taken from the synchronized copy.
module key_sync_edge (
    input  logic clk,
    input  logic resetN,
    input  logic key_i,
    output logic key_sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q, sync2_q, prev_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign key_sync_o = sync2_q;
    assign rise_o     = sync2_q & ~prev_q;
    assign fall_o     = ~sync2_q & prev_q;

endmodule

// File: rtl/bird_launcher.sv
// Launch controller: charges on a held fire key, requests a bird show and
// tracks flight, cooldown and bird count. BIRD_LAUNCHER_AUTO_RELOAD_EN enables
// automatic reload after RELOAD_FRAMES frames in EMPTY.
module bird_launcher
    import bird_launcher_pkg::*;
#(
    parameter int MIN_SPEED       = FIXED_POINT_MULTIPLIER,
    parameter int SPEED_STEP      = 16,
    parameter int MAX_CHARGE      = 15,
    parameter int BIRDS_PER_GAME  = 3,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int ARM_TIMEOUT     = 30,
    parameter int RELOAD_FRAMES   = 60
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      startOfFrame,
    input  logic                      fireKey,
    input  logic                      newGame,
    input  logic                      shootBirdPulse,
    input  logic                      displayBird,
    output logic                      showBird,
    output logic signed [SPEED_W-1:0] launchSpeed,
    output logic [3:0]                chargeLevel,
    output logic [BIRD_W-1:0]         birdsLeft,
    output logic                      launcherBusy
);

    launcher_state_t      state_q, state_d;
    logic [3:0]           charge_q, charge_d;
    logic [SPEED_W-1:0]   speed_q, speed_d;
    logic [BIRD_W-1:0]    birds_q, birds_d;
    logic                 show_q, show_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 seen_q, seen_d;
    logic                 key_held, key_rise, key_fall;

    key_sync_edge u_fire_sync (
        .clk        (clk),
        .resetN     (resetN),
        .key_i      (fireKey),
        .key_sync_o (key_held),
        .rise_o     (key_rise),
        .fall_o     (key_fall)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= ST_IDLE;
            charge_q <= '0;
            speed_q  <= SPEED_W'(MIN_SPEED);
            birds_q  <= BIRD_W'(BIRDS_PER_GAME);
            show_q   <= 1'b0;
            cnt_q    <= '0;
            seen_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            charge_q <= charge_d;
            speed_q  <= speed_d;
            birds_q  <= birds_d;
            show_q   <= show_d;
            cnt_q    <= cnt_d;
            seen_q   <= seen_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        charge_d = charge_q;
        speed_d  = speed_q;
        birds_d  = birds_q;
        show_d   = show_q;
        cnt_d    = cnt_q;
        seen_d   = seen_q;
        if (newGame) begin
            state_d  = ST_IDLE;
            charge_d = '0;
            birds_d  = BIRD_W'(BIRDS_PER_GAME);
            show_d   = 1'b0;
            cnt_d    = '0;
            seen_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (key_rise && birds_q != '0) begin
                        state_d  = ST_CHARGING;
                        charge_d = '0;
                    end
                end
                ST_CHARGING: begin
                    // A release in the same cycle as a frame tick uses the pre-increment charge.
                    if (key_fall) begin
                        speed_d = calc_speed(int'(charge_q), MIN_SPEED, SPEED_STEP);
                        show_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_ARMED;
                    end else if (startOfFrame && key_held && charge_q < 4'(MAX_CHARGE)) begin
                        charge_d = charge_q + 4'd1;
                    end
                end
                ST_ARMED: begin
                    if (shootBirdPulse) begin
                        show_d   = 1'b0;
                        birds_d  = birds_q - BIRD_W'(1);
                        charge_d = '0;
                        cnt_d    = '0;
                        seen_d   = 1'b0;
                        state_d  = ST_IN_FLIGHT;
                    end else if (startOfFrame) begin
                        if (cnt_q == 16'(ARM_TIMEOUT - 1)) begin
                            show_d  = 1'b0;
                            cnt_d   = '0;
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                end
                ST_IN_FLIGHT: begin
                    // seen_q marks that the bird has been visible; a low after that is the fall.
                    if (displayBird) begin
                        seen_d = 1'b1;
                    end else if (seen_q) begin
                        cnt_d   = '0;
                        state_d = ST_COOLDOWN;
                    end else if (startOfFrame) begin
                        if (cnt_q == 16'd1) begin
                            cnt_d   = '0;
                            state_d = ST_COOLDOWN;
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                end
                ST_COOLDOWN: begin
                    if (startOfFrame) begin
                        if (cnt_q == 16'(COOLDOWN_FRAMES - 1)) begin
                            cnt_d   = '0;
                            state_d = (birds_q != '0) ? ST_IDLE : ST_EMPTY;
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                end
                ST_EMPTY: begin
`ifdef BIRD_LAUNCHER_AUTO_RELOAD_EN
                    if (startOfFrame) begin
                        if (cnt_q == 16'(RELOAD_FRAMES - 1)) begin
                            cnt_d   = '0;
                            birds_d = BIRD_W'(BIRDS_PER_GAME);
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
`else
                    state_d = ST_EMPTY;
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign showBird     = show_q;
    assign launchSpeed  = signed'(speed_q);
    assign chargeLevel  = charge_q;
    assign birdsLeft    = birds_q;
    assign launcherBusy = (state_q != ST_IDLE);

endmodule
